lsq_mem_arbiter: RTL
====================

Name: lsq_mem_arbiter

Overview:
Shares the single-port compute-unit data memory among NUM_REQ load/store queues (one LSQ per thread group) using round-robin arbitration.
Accepts one LD/ST request at a time and drives the data-memory read/write enables, address and write data. Returns load data or a store-done pulse to the winning LSQ.
Sits between the LSQs and data memory. It replaces direct LSQ-to-memory enable decoding, so the per-LSQ done/instr bits become request/response handshakes.

Parameters:
NUM_REQ, 4, number of requesting LSQs (>=2)
AW, 8, data-memory address width
DW, 16, data word width
MEM_LAT, 2, read latency in cycles from mem_read_en to valid mem_rdata (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-LSQ request pending; held with fields stable until accepted
req_store  in  NUM_REQ  per-LSQ request type: 1 = ST, 0 = LD
req_addr  in  NUM_REQ*AW  packed addresses; slot i at [i*AW +: AW]
req_wdata  in  NUM_REQ*DW  packed store data; slot i at [i*DW +: DW]
req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i]
resp_valid  out  NUM_REQ  one-hot single-cycle completion pulse to the owning LSQ
resp_rdata  out  DW  load data; valid with resp_valid; 0 for stores
busy  out  1  transaction in flight (state != IDLE)
mem_read_en  out  1  data-memory read strobe
mem_write_en  out  1  data-memory write strobe
mem_addr  out  AW  data-memory address
mem_wdata  out  DW  data-memory write data
mem_rdata  in  DW  data-memory read data

Behaviour:
- Reset:
  - state = IDLE, rr_ptr = 0, latched owner/type/addr/wdata = 0, wait counter = 0, resp_rdata = 0.
  - All outputs 0.
  - A reset during ISSUE/WAIT/RESP abandons the transaction: no resp_valid, no further mem strobes.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first index i at or after rr_ptr (scanning upward, wrapping modulo NUM_REQ) with req_valid[i] = 1.
  - req_ready is combinational, asserted only for g, and only in IDLE.
  - On accept: latch g, req_store[g], addr and wdata; go to ISSUE.
  - No valid requester: stay in IDLE with req_ready = 0.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched addr.
  - Store: mem_write_en = 1, mem_wdata = latched wdata; go to RESP.
  - Load: mem_read_en = 1; load the counter with MEM_LAT; go to WAIT.
  - Never assert both strobes.
- WAIT:
  - Decrement the counter each cycle.
  - The cycle the counter reaches 1, register mem_rdata into resp_rdata and go to RESP.
  - Net effect: data is sampled MEM_LAT cycles after the mem_read_en cycle.
- RESP (exactly 1 cycle):
  - resp_valid[owner] = 1.
  - resp_rdata = captured data for loads, 0 for stores.
  - rr_ptr <= (owner + 1) mod NUM_REQ; go to IDLE.
- Outside ISSUE: mem strobes = 0; mem_addr and mem_wdata hold their last values (no requirement on them).
- Latency, with accept in cycle T:
  - Store: strobe at T+1, resp at T+2.
  - Load: strobe at T+1, data sampled at T+1+MEM_LAT, resp at T+2+MEM_LAT.
  - Next accept no earlier than the cycle after RESP.
- Fairness: a continuously valid requester is served within NUM_REQ transactions.
- rr_ptr wraps from NUM_REQ-1 to 0.
- A requester dropping req_valid before acceptance is legal; it simply loses that slot.
- Counter width = clog2(MEM_LAT+1).

Test Plan:
1. Reset, then req 2 LD addr 0x10 (NUM_REQ=4, MEM_LAT=2; memory returns 0xBEEF) -> req_ready[2] at T, mem_read_en at T+1 with mem_addr 0x10, resp_valid = 0100 with resp_rdata 0xBEEF at T+4.
2. Req 1 ST addr 0x20 data 0x1234 -> mem_write_en = 1 at T+1 with addr 0x20 / data 0x1234, resp_valid = 0010 at T+2, resp_rdata 0, mem_read_en never asserted.
3. All four req_valid held high with loads -> grant order 0,1,2,3,0; rr_ptr wraps to 0 after req 3; each response is one-hot to the correct index.
4. rr_ptr = 3 with only req 1 valid -> grant 1 (wrap scan); afterwards rr_ptr = 2.
5. Assert reset during WAIT of a load -> next cycle state IDLE, all outputs 0, no resp_valid for that load; a new req 0 is then granted first.
6. Idle with no req_valid for 10 cycles -> req_ready, strobes, resp_valid and busy all stay 0; a later ST then completes in 2 cycles.

Source files
------------

// File: rtl/lsq_mem_arbiter_if.sv
// rtl/lsq_mem_arbiter_if.sv - LSQ request/response and data-memory bus bundle
// master = LSQ/memory side, slave = arbiter side.
interface lsq_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 16
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_store;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [DW-1:0]         resp_rdata;
  logic                  busy;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         mem_rdata;

  modport master (
    output req_valid, req_store, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, busy,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_store, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, busy,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// rtl/lsq_mem_arbiter.sv - round-robin arbiter sharing one data memory among LSQs
// One transaction in flight; strobes and responses are registered outputs.
module lsq_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  lsq_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic               is_store;
  logic [CW-1:0]      cnt;
  logic [IW-1:0]      grant_idx;
  logic               found;
  logic [NUM_REQ-1:0] ready;

  // Scan upward from rr_ptr, wrapping, for the first pending requester.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == IDLE && !reset && found) ready[grant_idx] = 1'b1;
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      owner            <= '0;
      is_store         <= 1'b0;
      cnt              <= '0;
      bus.resp_valid   <= '0;
      bus.resp_rdata   <= '0;
      bus.busy         <= 1'b0;
      bus.mem_read_en  <= 1'b0;
      bus.mem_write_en <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner            <= grant_idx;
            is_store         <= bus.req_store[grant_idx];
            bus.mem_addr     <= bus.req_addr[grant_idx*AW +: AW];
            bus.mem_wdata    <= bus.req_wdata[grant_idx*DW +: DW];
            bus.mem_write_en <= bus.req_store[grant_idx];
            bus.mem_read_en  <= !bus.req_store[grant_idx];
            bus.busy         <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          bus.mem_read_en  <= 1'b0;
          bus.mem_write_en <= 1'b0;
          if (is_store) begin
            bus.resp_valid <= NUM_REQ'(1) << owner;
            bus.resp_rdata <= '0;
            state          <= RESP;
          end else begin
            cnt   <= CW'(MEM_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Count 1 marks the cycle that is MEM_LAT after the read strobe.
          if (cnt == CW'(1)) begin
            bus.resp_rdata <= bus.mem_rdata;
            bus.resp_valid <= NUM_REQ'(1) << owner;
            state          <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= '0;
          bus.busy       <= 1'b0;
          rr_ptr         <= (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
